// File: rtl/cv32e40p_rf_par_pkg.sv
// Shared types and the group-parity helper for the parity-protected register file.
package cv32e40p_rf_par_pkg;

    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        ERR_SRC_A     = 2'd0,
        ERR_SRC_B     = 2'd1,
        ERR_SRC_C     = 2'd2,
        ERR_SRC_SCRUB = 2'd3
    } err_src_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK
    } scrub_state_e;

    // Even parity of group k, where a group is grp consecutive data bits.
    function automatic logic grp_parity(input logic [MAX_DATA_W-1:0] data,
                                        input int unsigned grp,
                                        input int unsigned k);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i >= k * grp && i < (k + 1) * grp) begin
                p ^= data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/cv32e40p_register_file_par_scrub_scrubber.sv
// Background scrubber: waits SCRUB_INTERVAL cycles, checks one word, advances the pointer.
module cv32e40p_rf_scrubber
    import cv32e40p_rf_par_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NUM_WORDS      = 32,
    parameter int unsigned SCRUB_INTERVAL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scrub_en,
    input  logic                  mismatch,
    output logic [ADDR_WIDTH-1:0] scrub_addr,
    output logic                  check,
    output logic                  scrub_err
);

    localparam int unsigned CNT_W = (SCRUB_INTERVAL < 2) ? 1 : $clog2(SCRUB_INTERVAL + 1);

    scrub_state_e          state, state_next;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_next;
    logic [ADDR_WIDTH-1:0] ptr, ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ptr      <= ptr_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        ptr_next      = ptr;
        check         = 1'b0;
        if (!scrub_en) begin
            state_next    = S_IDLE;
            wait_cnt_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next    = S_WAIT;
                    wait_cnt_next = '0;
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(SCRUB_INTERVAL - 1)) begin
                        state_next    = S_CHECK;
                        wait_cnt_next = '0;
                    end else begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    check      = 1'b1;
                    ptr_next   = (ptr == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : ptr + 1'b1;
                    state_next = S_WAIT;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign scrub_addr = ptr;
    assign scrub_err  = check & mismatch;

endmodule

// File: rtl/cv32e40p_register_file_par_scrub.sv
// Parity-protected flip-flop register file with error capture, counter and fault injection.
// Optional background scrubber is built when CV32E40P_RF_SCRUB_EN is defined.
module cv32e40p_register_file_par_scrub
    import cv32e40p_rf_par_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PAR_GRP        = 8,
    parameter int unsigned FPU            = 0,
    parameter int unsigned ZFINX          = 0,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned SCRUB_INTERVAL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_cg_en_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    input  logic                  ren_a_i,
    input  logic                  ren_b_i,
    input  logic                  ren_c_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic [DATA_WIDTH-1:0] rdata_c_o,
    output logic                  rerr_a_o,
    output logic                  rerr_b_o,
    output logic                  rerr_c_o,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic                  inj_flip_i,
    input  logic                  scrub_en_i,
    output logic                  err_valid_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [1:0]            err_src_o,
    input  logic                  err_ack_i,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    localparam bit          HAS_FP        = (FPU != 0) && (ZFINX == 0);
    localparam int unsigned IDX_W         = HAS_FP ? ADDR_WIDTH : ADDR_WIDTH - 1;
    localparam int unsigned NUM_TOT_WORDS = 2 ** IDX_W;
    localparam int unsigned PAR_BITS      = DATA_WIDTH / PAR_GRP;
    localparam int unsigned WORD_W        = DATA_WIDTH + PAR_BITS;

    logic [WORD_W-1:0] mem [NUM_TOT_WORDS];

    function automatic logic [PAR_BITS-1:0] calc_par(input logic [DATA_WIDTH-1:0] d);
        logic [PAR_BITS-1:0] p;
        p = '0;
        for (int unsigned k = 0; k < PAR_BITS; k++) begin
            p[k] = grp_parity(MAX_DATA_W'(d), PAR_GRP, k);
        end
        return p;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return HAS_FP ? 1'b1 : ~a[ADDR_WIDTH-1];
    endfunction

    function automatic logic word_err(input logic [WORD_W-1:0] w);
        return calc_par(w[WORD_W-1 -: DATA_WIDTH]) != w[PAR_BITS-1:0];
    endfunction

    // ---------------- read ports ----------------
    logic [ADDR_WIDTH-1:0] raddr [3];
    logic [WORD_W-1:0]     rword [3];
    logic [2:0]            rerr;

    assign raddr[0] = raddr_a_i;
    assign raddr[1] = raddr_b_i;
    assign raddr[2] = raddr_c_i;

    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            rword[p] = in_range(raddr[p]) ? mem[raddr[p][IDX_W-1:0]] : '0;
            rerr[p]  = word_err(rword[p]);
        end
    end

    assign rdata_a_o = rword[0][WORD_W-1 -: DATA_WIDTH];
    assign rdata_b_o = rword[1][WORD_W-1 -: DATA_WIDTH];
    assign rdata_c_o = rword[2][WORD_W-1 -: DATA_WIDTH];
    assign rerr_a_o  = rerr[0];
    assign rerr_b_o  = rerr[1];
    assign rerr_c_o  = rerr[2];

    // ---------------- write ports ----------------
    logic              wr_a_ok, wr_b_ok;
    logic [WORD_W-1:0] wword_a, wword_b;

    always_comb begin
        wr_a_ok = we_a_i && in_range(waddr_a_i) && (waddr_a_i != '0);
        wr_b_ok = we_b_i && in_range(waddr_b_i) && (waddr_b_i != '0);
        wword_a = {wdata_a_i, calc_par(wdata_a_i) ^ PAR_BITS'(inj_flip_i)};
        wword_b = {wdata_b_i, calc_par(wdata_b_i)};
    end

    // Word 0 is only ever reset, so x0 stays zero with zero parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TOT_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_TOT_WORDS; i++) begin
                if (wr_b_ok && waddr_b_i[IDX_W-1:0] == IDX_W'(i)) begin
                    mem[i] <= wword_b;
                end else if (wr_a_ok && waddr_a_i[IDX_W-1:0] == IDX_W'(i)) begin
                    mem[i] <= wword_a;
                end
            end
        end
    end

    // ---------------- scrubber ----------------
    logic             det_s;
    logic [IDX_W-1:0] scrub_addr;

`ifdef CV32E40P_RF_SCRUB_EN
    logic scrub_check;
    logic scrub_mismatch;

    assign scrub_mismatch = word_err(mem[scrub_addr]);

    cv32e40p_rf_scrubber #(
        .ADDR_WIDTH    (IDX_W),
        .NUM_WORDS     (NUM_TOT_WORDS),
        .SCRUB_INTERVAL(SCRUB_INTERVAL)
    ) u_scrubber (
        .clk       (clk),
        .rst       (rst),
        .scrub_en  (scrub_en_i),
        .mismatch  (scrub_mismatch),
        .scrub_addr(scrub_addr),
        .check     (scrub_check),
        .scrub_err (det_s)
    );
`else
    logic unused_scrub_en;
    assign unused_scrub_en = scrub_en_i;
    assign det_s           = 1'b0;
    assign scrub_addr      = '0;
`endif

    logic unused_scan_cg;
    assign unused_scan_cg = scan_cg_en_i;

    // ---------------- error capture and counter ----------------
    logic [3:0]            det;
    logic                  any_det;
    err_src_e              det_src, err_src;
    logic [ADDR_WIDTH-1:0] det_addr;

    always_comb begin
        det      = {det_s, rerr[2] & ren_c_i, rerr[1] & ren_b_i, rerr[0] & ren_a_i};
        any_det  = |det;
        det_src  = ERR_SRC_SCRUB;
        det_addr = ADDR_WIDTH'(scrub_addr);
        if (det[0]) begin
            det_src  = ERR_SRC_A;
            det_addr = raddr_a_i;
        end else if (det[1]) begin
            det_src  = ERR_SRC_B;
            det_addr = raddr_b_i;
        end else if (det[2]) begin
            det_src  = ERR_SRC_C;
            det_addr = raddr_c_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_src     <= ERR_SRC_A;
            err_cnt_o   <= '0;
        end else begin
            if (!err_valid_o || err_ack_i) begin
                if (any_det) begin
                    err_valid_o <= 1'b1;
                    err_addr_o  <= det_addr;
                    err_src     <= det_src;
                end else if (err_ack_i) begin
                    err_valid_o <= 1'b0;
                end
            end
            if (any_det && err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

    assign err_src_o = err_src;

endmodule

// File: tb/tb_cv32e40p_register_file_par_scrub.sv
// Self-checking bench for cv32e40p_register_file_par_scrub (scrub test needs CV32E40P_RF_SCRUB_EN).
module tb_cv32e40p_register_file_par_scrub;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          scan_cg_en = 1'b0;
    logic [AW-1:0] raddr_a = '0, raddr_b = '0, raddr_c = '0;
    logic          ren_a = 1'b0, ren_b = 1'b0, ren_c = 1'b0;
    logic [DW-1:0] rdata_a, rdata_b, rdata_c;
    logic          rerr_a, rerr_b, rerr_c;
    logic [AW-1:0] waddr_a = '0, waddr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          we_a = 1'b0, we_b = 1'b0, inj_flip = 1'b0;
    logic          scrub_en = 1'b0;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic [1:0]    err_src;
    logic          err_ack = 1'b0;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    cv32e40p_register_file_par_scrub #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAR_GRP(8), .FPU(0), .ZFINX(0),
        .CNT_WIDTH(CW), .SCRUB_INTERVAL(1)
    ) dut (
        .clk(clk), .rst(rst), .scan_cg_en_i(scan_cg_en),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
        .ren_a_i(ren_a), .ren_b_i(ren_b), .ren_c_i(ren_c),
        .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rdata_c_o(rdata_c),
        .rerr_a_o(rerr_a), .rerr_b_o(rerr_b), .rerr_c_o(rerr_c),
        .waddr_a_i(waddr_a), .waddr_b_i(waddr_b),
        .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
        .we_a_i(we_a), .we_b_i(we_b), .inj_flip_i(inj_flip),
        .scrub_en_i(scrub_en),
        .err_valid_o(err_valid), .err_addr_o(err_addr), .err_src_o(err_src),
        .err_ack_i(err_ack), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    wire [16:0] cap = {err_valid, err_addr, err_src, err_cnt};

    function automatic logic [16:0] mk_cap(input logic v, input logic [5:0] a,
                                           input logic [1:0] s, input logic [7:0] c);
        return {v, a, s, c};
    endfunction

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    rd_exp_t sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; inj_flip = 1'b0; err_ack = 1'b0;
        ren_a = 1'b0; ren_b = 1'b0; ren_c = 1'b0;
        raddr_a = '0; raddr_b = '0; raddr_c = '0;
    endtask

    task automatic wr(input bit port_b, input logic [5:0] a, input logic [31:0] d, input bit inj);
        if (port_b) begin
            we_b = 1'b1; waddr_b = a; wdata_b = d;
        end else begin
            we_a = 1'b1; waddr_a = a; wdata_a = d; inj_flip = inj;
        end
        step();
        we_a = 1'b0; we_b = 1'b0; inj_flip = 1'b0;
    endtask

    task automatic sb_read(input int port, input logic [5:0] a, input logic ren,
                           input logic [31:0] d, input logic e);
        rd_exp_t x;
        case (port)
            0: begin raddr_a = a; ren_a = ren; end
            1: begin raddr_b = a; ren_b = ren; end
            default: begin raddr_c = a; ren_c = ren; end
        endcase
        x.port = port; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic sb_drain();
        rd_exp_t     x;
        logic [31:0] d;
        logic        e;
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.port)
                0: begin d = rdata_a; e = rerr_a; end
                1: begin d = rdata_b; e = rerr_b; end
                default: begin d = rdata_c; e = rerr_c; end
            endcase
            checks++;
            if ({d, e} !== {x.data, x.err}) begin
                errors++;
                $display("FAIL read_port%0d: got data %h err %b, expected data %h err %b",
                         x.port, d, e, x.data, x.err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); step(); step(); rst = 1'b0;
        checks++;
        if (cap !== mk_cap(0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_capture: got %h expected %h", cap, mk_cap(0, 0, 0, 0));
        end
        sb_read(0, 6'd5, 1'b0, 32'h0, 1'b0);
        sb_drain();
    endtask

    task automatic test_basic();
        wr(0, 6'd5, 32'hDEADBEEF, 0);
        sb_read(0, 6'd5, 1'b1, 32'hDEADBEEF, 1'b0);
        sb_read(1, 6'd5, 1'b1, 32'hDEADBEEF, 1'b0);
        sb_read(2, 6'd5, 1'b1, 32'hDEADBEEF, 1'b0);
        sb_drain(); step(); idle();
        checks++;
        if (cap !== mk_cap(0, 0, 0, 0)) begin
            errors++; $display("FAIL basic_capture: got %h expected %h", cap, mk_cap(0, 0, 0, 0));
        end
    endtask

    task automatic test_inject();
        wr(0, 6'd7, 32'h12345678, 1);
        sb_read(1, 6'd7, 1'b1, 32'h12345678, 1'b1);
        sb_drain(); step(); idle();
        checks++;
        if (cap !== mk_cap(1, 7, 1, 1)) begin
            errors++; $display("FAIL inject_capture: got %h expected %h", cap, mk_cap(1, 7, 1, 1));
        end
        err_ack = 1'b1; step(); idle();
        checks++;
        if ({err_valid, err_cnt} !== {1'b1 ^ 1'b1, 8'd1}) begin
            errors++; $display("FAIL ack_clear: got valid %b cnt %0d expected valid 0 cnt 1", err_valid, err_cnt);
        end
        wr(0, 6'd7, 32'h12345678, 0);
        sb_read(0, 6'd7, 1'b1, 32'h12345678, 1'b0);
        sb_drain(); step(); idle();
        checks++;
        if ({err_valid, err_cnt} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL rewrite_clean: got valid %b cnt %0d expected valid 0 cnt 1", err_valid, err_cnt);
        end
    endtask

    task automatic test_priority();
        wr(0, 6'd3, 32'h00000033, 1);
        wr(0, 6'd4, 32'h00000044, 1);
        sb_read(0, 6'd4, 1'b1, 32'h00000044, 1'b1);
        sb_read(2, 6'd3, 1'b1, 32'h00000033, 1'b1);
        sb_drain(); step(); idle();
        checks++;
        if (cap !== mk_cap(1, 4, 0, 2)) begin
            errors++; $display("FAIL prio_a_over_c: got %h expected %h", cap, mk_cap(1, 4, 0, 2));
        end
        sb_read(2, 6'd3, 1'b1, 32'h00000033, 1'b1);
        sb_drain(); step(); idle();
        checks++;
        if (cap !== mk_cap(1, 4, 0, 3)) begin
            errors++; $display("FAIL hold_no_ack: got %h expected %h", cap, mk_cap(1, 4, 0, 3));
        end
        err_ack = 1'b1;
        sb_read(2, 6'd3, 1'b1, 32'h00000033, 1'b1);
        sb_drain(); step(); idle();
        checks++;
        if (cap !== mk_cap(1, 3, 2, 4)) begin
            errors++; $display("FAIL ack_reload: got %h expected %h", cap, mk_cap(1, 3, 2, 4));
        end
        err_ack = 1'b1;
        sb_read(0, 6'd3, 1'b0, 32'h00000033, 1'b1);
        sb_drain(); step(); idle();
        checks++;
        if ({err_valid, err_cnt} !== {1'b0, 8'd4}) begin
            errors++; $display("FAIL ren_qualify: got valid %b cnt %0d expected valid 0 cnt 4", err_valid, err_cnt);
        end
        sb_read(1, 6'd4, 1'b1, 32'h00000044, 1'b1);
        sb_read(2, 6'd3, 1'b1, 32'h00000033, 1'b1);
        sb_drain(); step(); idle();
        checks++;
        if (cap !== mk_cap(1, 4, 1, 5)) begin
            errors++; $display("FAIL prio_b_over_c: got %h expected %h", cap, mk_cap(1, 4, 1, 5));
        end
        err_ack = 1'b1; step(); idle();
    endtask

    task automatic test_back_to_back();
        we_a = 1'b1; waddr_a = 6'd9; wdata_a = 32'h1;
        we_b = 1'b1; waddr_b = 6'd9; wdata_b = 32'h2;
        step();
        we_a = 1'b1; waddr_a = 6'd11; wdata_a = 32'hA5A5A5A5;
        we_b = 1'b1; waddr_b = 6'd12; wdata_b = 32'h5A5A5A5A;
        sb_read(0, 6'd9, 1'b1, 32'h2, 1'b0);
        sb_drain(); step();
        we_a = 1'b1; waddr_a = 6'd13; wdata_a = 32'h13131313; we_b = 1'b0;
        sb_read(0, 6'd11, 1'b1, 32'hA5A5A5A5, 1'b0);
        sb_read(1, 6'd12, 1'b1, 32'h5A5A5A5A, 1'b0);
        sb_read(2, 6'd13, 1'b1, 32'h0, 1'b0);
        sb_drain(); step(); idle();
        sb_read(2, 6'd13, 1'b1, 32'h13131313, 1'b0);
        sb_drain(); step(); idle();
        wr(0, 6'd0, 32'hFFFFFFFF, 1);
        wr(1, 6'd0, 32'h0000FFFF, 0);
        wr(0, 6'd40, 32'hCAFEF00D, 0);
        sb_read(0, 6'd0, 1'b1, 32'h0, 1'b0);
        sb_read(1, 6'd40, 1'b1, 32'h0, 1'b0);
        sb_read(2, 6'd37, 1'b1, 32'h0, 1'b0);
        sb_drain(); step(); idle();
        sb_read(0, 6'd5, 1'b1, 32'hDEADBEEF, 1'b0);
        sb_read(1, 6'd8, 1'b1, 32'h0, 1'b0);
        sb_drain(); step(); idle();
        checks++;
        if ({err_valid, err_cnt} !== {1'b0, 8'd5}) begin
            errors++; $display("FAIL no_spurious: got valid %b cnt %0d expected valid 0 cnt 5", err_valid, err_cnt);
        end
    endtask

    task automatic test_saturation();
        raddr_a = 6'd3; ren_a = 1'b1;
        repeat (300) step();
        idle();
        checks++;
        if (cap !== mk_cap(1, 3, 0, 8'd255)) begin
            errors++; $display("FAIL cnt_saturate: got %h expected %h", cap, mk_cap(1, 3, 0, 8'd255));
        end
    endtask

    task automatic test_reset_mid();
        raddr_a = 6'd3; ren_a = 1'b1;
        we_a = 1'b1; waddr_a = 6'd14; wdata_a = 32'h0000FFFF;
        rst = 1'b1; step(); rst = 1'b0; idle();
        checks++;
        if (cap !== mk_cap(0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_mid: got %h expected %h", cap, mk_cap(0, 0, 0, 0));
        end
        sb_read(0, 6'd14, 1'b1, 32'h0, 1'b0);
        sb_read(1, 6'd3, 1'b1, 32'h0, 1'b0);
        sb_read(2, 6'd5, 1'b1, 32'h0, 1'b0);
        sb_drain(); step(); idle();
    endtask

`ifdef CV32E40P_RF_SCRUB_EN
    task automatic test_scrub();
        int n;
        rst = 1'b1; idle(); step(); rst = 1'b0;
        wr(0, 6'd10, 32'hABCD0123, 1);
        scrub_en = 1'b1;
        n = 0;
        while (!err_valid && n < 200) begin step(); n++; end
        checks++;
        if (cap !== mk_cap(1, 10, 3, 1) || n < 21 || n > 24) begin
            errors++; $display("FAIL scrub_detect: got %h after %0d cycles expected %h after ~23", cap, n, mk_cap(1, 10, 3, 1));
        end
        err_ack = 1'b1; scrub_en = 1'b0; step(); err_ack = 1'b0;
        repeat (5) step();
        scrub_en = 1'b1;
        n = 0;
        while (!err_valid && n < 200) begin step(); n++; end
        checks++;
        if (cap !== mk_cap(1, 10, 3, 2) || n < 40 || n >= 200) begin
            errors++; $display("FAIL scrub_resume: got %h after %0d cycles expected %h after >40", cap, n, mk_cap(1, 10, 3, 2));
        end
        scrub_en = 1'b0; step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_inject();
        test_priority();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
`ifdef CV32E40P_RF_SCRUB_EN
        test_scrub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
